// File: rtl/sram_banked_pkg.sv
// Shared configuration, derived widths and address helpers for the banked multi-port SRAM.
package sram_banked_pkg;

    localparam int unsigned DATA_WIDTH = 112;
    localparam int unsigned DEPTH      = 128;
    localparam int unsigned MASK_GRAN  = 8;
    localparam int unsigned NUM_BANKS  = 2;
    localparam int unsigned NUM_PORTS  = 2;

    localparam int unsigned ADDR_W     = $clog2(DEPTH);
    localparam int unsigned BANK_SH    = $clog2(NUM_BANKS);
    localparam int unsigned BANK_W     = (NUM_BANKS > 1) ? BANK_SH : 1;
    localparam int unsigned ROW_W      = ADDR_W - BANK_SH;
    localparam int unsigned ROWS       = DEPTH / NUM_BANKS;
    localparam int unsigned NUM_WMASKS = DATA_WIDTH / MASK_GRAN;
    localparam int unsigned PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef logic [NUM_PORTS-1:0] grant_t;

    typedef enum logic [0:0] {StInit, StReady} init_state_e;

    function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] addr);
        if (NUM_BANKS == 1) return '0;
        return addr[BANK_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
        return ROW_W'(addr >> BANK_SH);
    endfunction

endpackage

// File: rtl/sram_banked_mp_if.sv
// Request/response bundle of sram_banked_mp; port p occupies slice p of every vector.
interface sram_banked_mp_if;
    import sram_banked_pkg::*;

    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            req_we;
    logic [NUM_PORTS*ADDR_W-1:0]     req_addr;
    logic [NUM_PORTS*NUM_WMASKS-1:0] req_wmask;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata;
    logic                            init_done;

    modport master (
        output req_valid, req_we, req_addr, req_wmask, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wmask, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_done
    );

endinterface

// File: rtl/sram_bank.sv
// One SRAM bank: row array with lane-masked writes and a registered read port.
module sram_bank #(
    parameter int unsigned Rows  = 64,
    parameter int unsigned RowW  = 6,
    parameter int unsigned Width = 112,
    parameter int unsigned Gran  = 8,
    parameter int unsigned Lanes = 14
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [RowW-1:0]  row,
    input  logic [Lanes-1:0] wmask,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Rows];
    logic [Width-1:0] rdata_q;

    // Array and read register are deliberately never reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int unsigned i = 0; i < Lanes; i++) begin
                if (wmask[i]) mem[row][i*Gran +: Gran] <= wdata[i*Gran +: Gran];
            end
        end
        if (en && !we) rdata_q <= mem[row];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_banked_mp.sv
// Multi-port banked SRAM: per-bank round-robin arbitration, 1-cycle reads.
// Optional zero-fill sweep after reset when SRAM_INIT_EN is defined.
module sram_banked_mp
    import sram_banked_pkg::*;
(
    input  logic              clk_g,
    input  logic              rstn_g,
    sram_banked_mp_if.slave   bus
);

    init_state_e                 state_q;
    logic                        init_done_q;
    logic                        sweep;
    logic [ROW_W-1:0]            sweep_row;

    logic [NUM_PORTS-1:0]        port_req [NUM_BANKS];
    grant_t                      grant    [NUM_BANKS];
    logic [PTR_W-1:0]            ptr_q    [NUM_BANKS];
    logic [PTR_W-1:0]            ptr_d    [NUM_BANKS];
    logic                        found;
    logic [NUM_PORTS-1:0]        ready;
    logic [NUM_PORTS-1:0]        rd_acc;

    logic                        bank_en    [NUM_BANKS];
    logic                        bank_we    [NUM_BANKS];
    logic [ROW_W-1:0]            bank_row   [NUM_BANKS];
    logic [NUM_WMASKS-1:0]       bank_wmask [NUM_BANKS];
    logic [DATA_WIDTH-1:0]       bank_wdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0]       bank_rdata [NUM_BANKS];

    logic [NUM_PORTS-1:0]        rsp_valid_q;
    logic [BANK_W-1:0]           sel_q  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]       hold_q [NUM_PORTS];
    logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata;

`ifdef SRAM_INIT_EN
    logic [ROW_W-1:0] row_q;
    assign sweep     = (state_q == StInit);
    assign sweep_row = row_q;
`else
    assign sweep     = 1'b0;
    assign sweep_row = '0;
`endif

    always_ff @(posedge clk_g or negedge rstn_g) begin
        if (!rstn_g) begin
            state_q     <= StInit;
            init_done_q <= 1'b0;
`ifdef SRAM_INIT_EN
            row_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StInit: begin
`ifdef SRAM_INIT_EN
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        state_q     <= StReady;
                        init_done_q <= 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
`else
                    state_q     <= StReady;
                    init_done_q <= 1'b1;
`endif
                end
                StReady: state_q <= StReady;
                default: state_q <= StInit;
            endcase
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                port_req[b][p] = init_done_q && bus.req_valid[p] &&
                                 (addr_bank(bus.req_addr[p*ADDR_W +: ADDR_W]) == BANK_W'(b));
            end
        end
    end

    // Scan ports starting at the pointer; first requester wins, priority moves past it.
    always_comb begin
        found = 1'b0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            grant[b] = '0;
            ptr_d[b] = ptr_q[b];
            found    = 1'b0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                for (int unsigned q = 0; q < NUM_PORTS; q++) begin
                    if (!found && port_req[b][q] &&
                        (q == (32'(ptr_q[b]) + i) % NUM_PORTS)) begin
                        found       = 1'b1;
                        grant[b][q] = 1'b1;
                        ptr_d[b]    = PTR_W'((q + 1) % NUM_PORTS);
                    end
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) ready = ready | grant[b];
        rd_acc = ready & ~bus.req_we;
    end

    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_en[b]    = sweep;
            bank_we[b]    = sweep;
            bank_row[b]   = sweep_row;
            bank_wmask[b] = '1;
            bank_wdata[b] = '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (grant[b][p]) begin
                    bank_en[b]    = 1'b1;
                    bank_we[b]    = bus.req_we[p];
                    bank_row[b]   = addr_row(bus.req_addr[p*ADDR_W +: ADDR_W]);
                    bank_wmask[b] = bus.req_wmask[p*NUM_WMASKS +: NUM_WMASKS];
                    bank_wdata[b] = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sram_bank #(
            .Rows  (ROWS),
            .RowW  (ROW_W),
            .Width (DATA_WIDTH),
            .Gran  (MASK_GRAN),
            .Lanes (NUM_WMASKS)
        ) u_bank (
            .clk   (clk_g),
            .en    (bank_en[b]),
            .we    (bank_we[b]),
            .row   (bank_row[b]),
            .wmask (bank_wmask[b]),
            .wdata (bank_wdata[b]),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk_g or negedge rstn_g) begin
        if (!rstn_g) begin
            rsp_valid_q <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                sel_q[p]  <= '0;
                hold_q[p] <= '0;
            end
        end else begin
            rsp_valid_q <= rd_acc;
            for (int unsigned b = 0; b < NUM_BANKS; b++) ptr_q[b] <= ptr_d[b];
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (rd_acc[p]) sel_q[p] <= addr_bank(bus.req_addr[p*ADDR_W +: ADDR_W]);
                if (rsp_valid_q[p]) hold_q[p] <= bank_rdata[sel_q[p]];
            end
        end
    end

    // Bank read registers carry the data in the pulse cycle; hold_q keeps it afterwards.
    always_comb begin
        rsp_rdata = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = rsp_valid_q[p] ? bank_rdata[sel_q[p]] : hold_q[p];
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_sram_banked_mp.sv
// Directed bench for sram_banked_mp with a per-port read scoreboard and a shadow memory.
module tb_sram_banked_mp;
    import sram_banked_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sram_banked_mp_if bus ();

    sram_banked_mp dut (
        .clk_g  (clk),
        .rstn_g (rstn),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cnt;

    logic [DATA_WIDTH-1:0] model [DEPTH];
    logic [DATA_WIDTH-1:0] sb [NUM_PORTS][$];

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                         input logic [DATA_WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wmask = '0;
        bus.req_wdata = '0;
    endtask

    task automatic drive(input int p, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [NUM_WMASKS-1:0] m, input logic [DATA_WIDTH-1:0] d);
        bus.req_valid[p]                          = 1'b1;
        bus.req_we[p]                             = we;
        bus.req_addr[p*ADDR_W +: ADDR_W]          = a;
        bus.req_wmask[p*NUM_WMASKS +: NUM_WMASKS] = m;
        bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    // Model side effects of a request the bench expects to be accepted.
    task automatic accept(input int p, output logic is_read);
        logic [ADDR_W-1:0]     a;
        logic [NUM_WMASKS-1:0] m;
        logic [DATA_WIDTH-1:0] d;
        a = bus.req_addr[p*ADDR_W +: ADDR_W];
        m = bus.req_wmask[p*NUM_WMASKS +: NUM_WMASKS];
        d = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
        is_read = !bus.req_we[p];
        if (is_read) sb[p].push_back(model[a]);
        else
            for (int i = 0; i < int'(NUM_WMASKS); i++)
                if (m[i]) model[a][i*MASK_GRAN +: MASK_GRAN] = d[i*MASK_GRAN +: MASK_GRAN];
    endtask

    // Called at a negedge with inputs driven; returns at the following negedge.
    task automatic tick(input logic [NUM_PORTS-1:0] exp_ready);
        logic [NUM_PORTS-1:0] nxt;
        logic rd;
        nxt = '0;
        #1;
        check("req_ready", DATA_WIDTH'(bus.req_ready), DATA_WIDTH'(exp_ready));
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (exp_ready[p] && bus.req_valid[p]) begin
                accept(p, rd);
                nxt[p] = rd;
            end
        end
        @(posedge clk);
        #1;
        check("rsp_valid", DATA_WIDTH'(bus.rsp_valid), DATA_WIDTH'(nxt));
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (nxt[p]) check($sformatf("rsp_rdata[%0d]", p),
                              bus.rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH], sb[p].pop_front());
        end
        @(negedge clk);
    endtask

    task automatic wait_init(input int exp_cycles);
        cnt = 0;
        while (!bus.init_done && cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("init_latency", DATA_WIDTH'(cnt), DATA_WIDTH'(exp_cycles));
        check("rsp_valid_after_reset", DATA_WIDTH'(bus.rsp_valid), '0);
        @(negedge clk);
    endtask

    localparam int InitCycles =
`ifdef SRAM_INIT_EN
        ROWS;
`else
        1;
`endif

    initial begin
        logic rd;
        rstn = 1'b0;
        idle();
        drive(0, 1'b0, 7'd0, '0, '0);
        repeat (2) @(negedge clk);
        check("reset_req_ready", DATA_WIDTH'(bus.req_ready), '0);
        check("reset_rsp_valid", DATA_WIDTH'(bus.rsp_valid), '0);
        check("reset_rsp_rdata0", bus.rsp_rdata[0 +: DATA_WIDTH], '0);
        check("reset_init_done", DATA_WIDTH'(bus.init_done), '0);
        idle();
        rstn = 1'b1;
`ifdef SRAM_INIT_EN
        repeat (30) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
`endif
        #1;
        check("init_done_at_release", DATA_WIDTH'(bus.init_done), '0);
        wait_init(InitCycles);
`ifdef SRAM_INIT_EN
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        drive(0, 1'b0, 7'd100, '0, '0); tick(2'b01);
        idle();
`endif

        // Preload
        drive(0, 1'b1, 7'd5, '1, {14{8'h00}}); tick(2'b01);
        idle();
        drive(0, 1'b1, 7'd4, '1, {14{8'h3C}});
        drive(1, 1'b1, 7'd7, '1, {7{16'hBEEF}}); tick(2'b11);
        idle();
        drive(0, 1'b1, 7'd2, '1, {14{8'h12}}); tick(2'b01);
        idle();
        drive(1, 1'b1, 7'd6, '1, {14{8'h69}}); tick(2'b10);
        idle();

        // Masked write then read back; response data must persist after the pulse
        drive(0, 1'b1, 7'd5, 14'h0003, {14{8'hA5}}); tick(2'b01);
        drive(0, 1'b0, 7'd5, '0, '0); tick(2'b01);
        idle(); tick(2'b00);
        check("rsp_rdata0_held", bus.rsp_rdata[0 +: DATA_WIDTH], {{12{8'h00}}, 16'hA5A5});

        // Parallel banks
        drive(0, 1'b0, 7'd4, '0, '0);
        drive(1, 1'b0, 7'd7, '0, '0); tick(2'b11);
        idle();

        // Back-to-back write then read of the same address
        drive(1, 1'b1, 7'd9, '1, {4{28'h1234567}}); tick(2'b10);
        drive(1, 1'b0, 7'd9, '0, '0); tick(2'b10);
        idle();

        // Reset the cycle after a read is accepted, alongside a write that must persist
        drive(0, 1'b0, 7'd7, '0, '0);
        drive(1, 1'b1, 7'd10, '1, {14{8'h5A}});
        #1;
        check("pre_reset_ready", DATA_WIDTH'(bus.req_ready), DATA_WIDTH'(2'b11));
        accept(1, rd);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midreset_rsp_valid", DATA_WIDTH'(bus.rsp_valid), '0);
        check("midreset_rsp_rdata0", bus.rsp_rdata[0 +: DATA_WIDTH], '0);
        check("midreset_req_ready", DATA_WIDTH'(bus.req_ready), '0);
        check("midreset_init_done", DATA_WIDTH'(bus.init_done), '0);
        idle();
        @(negedge clk);
        rstn = 1'b1;
        wait_init(InitCycles);
`ifdef SRAM_INIT_EN
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
`endif
        drive(1, 1'b0, 7'd10, '0, '0); tick(2'b10);
        idle();

        // Bank-0 conflict with pointers fresh from reset: p0, p1, p0, p1
        drive(0, 1'b0, 7'd2, '0, '0);
        drive(1, 1'b0, 7'd6, '0, '0);
        tick(2'b01);
        tick(2'b10);
        tick(2'b01);
        tick(2'b10);
        idle(); tick(2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
